// File: rtl/ni_injector.sv
// Network-interface endpoint for a router's local port: segments descriptors into flits for injection
// and counts ejected flits/packets. Define NI_EJECT_CHECK_EN to enable ejection protocol checking on err.
module ni_injector #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [13:0] LOCAL_ID   = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [13:0] pkt_dst,
    input  logic [3:0]  pkt_vc,
    input  logic [3:0]  pkt_len,
    input  logic [15:0] can_inject,
    input  logic        inj_take,
    output logic [21:0] inj_flit,
    input  logic [21:0] ej_flit,
    input  logic        ej_strobe,
    output logic [15:0] rx_flits,
    output logic [15:0] rx_pkts,
    output logic        err,
    output logic        done
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Descriptor FIFO entry: {dst[13:0], vc[3:0], len[3:0]}
    logic [21:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [21:0] fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = pkt_valid && !fifo_full;
    assign pkt_ready  = !fifo_full;
    assign fifo_head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {pkt_dst, pkt_vc, pkt_len};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    state_t      state, state_n;
    logic [13:0] w_dst, w_dst_n;
    logic [3:0]  w_vc, w_vc_n;
    logic [3:0]  w_len, w_len_n;
    logic [3:0]  idx, idx_n;
    logic [21:0] flit_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            w_dst    <= '0;
            w_vc     <= '0;
            w_len    <= 4'd1;
            idx      <= '0;
            inj_flit <= '0;
        end else begin
            state    <= state_n;
            w_dst    <= w_dst_n;
            w_vc     <= w_vc_n;
            w_len    <= w_len_n;
            idx      <= idx_n;
            inj_flit <= flit_n;
        end
    end

    always_comb begin
        state_n = state;
        w_dst_n = w_dst;
        w_vc_n  = w_vc;
        w_len_n = w_len;
        idx_n   = idx;
        flit_n  = inj_flit;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_dst_n = fifo_head[21:8];
                    w_vc_n  = fifo_head[7:4];
                    w_len_n = (fifo_head[3:0] == 4'd0) ? 4'd1 : fifo_head[3:0];
                    idx_n   = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                flit_n = '0;
                if (can_inject[w_vc]) begin
                    flit_n  = {1'b1, w_vc, 1'b0, (idx == w_len - 4'd1), (idx == 4'd0), w_dst};
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inj_take) begin
                    flit_n = '0;
                    idx_n  = idx + 4'd1;
                    // The descriptor stays queued until its tail is taken.
                    if (inj_flit[15]) begin
                        pop     = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign done = fifo_empty && (state == S_IDLE) && !inj_flit[21];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_flits <= '0;
            rx_pkts  <= '0;
        end else if (ej_strobe && ej_flit[21]) begin
            rx_flits <= rx_flits + 16'd1;
            if (ej_flit[15]) begin
                rx_pkts <= rx_pkts + 16'd1;
            end
        end
    end

`ifdef NI_EJECT_CHECK_EN
    logic [15:0] in_pkt;
    logic        err_r;
    logic [3:0]  ej_vc;
    logic        ej_bad;
    logic        unused_ej;

    assign ej_vc     = ej_flit[20:17];
    assign ej_bad    = (ej_flit[13:0] != LOCAL_ID)
                    || ( ej_flit[14] &&  in_pkt[ej_vc])
                    || (!ej_flit[14] && !in_pkt[ej_vc]);
    assign err       = err_r;
    assign unused_ej = ej_flit[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            in_pkt <= '0;
            err_r  <= 1'b0;
        end else if (ej_strobe && ej_flit[21]) begin
            if (ej_bad) begin
                err_r <= 1'b1;
            end
            if (ej_flit[15]) begin
                in_pkt[ej_vc] <= 1'b0;
            end else if (ej_flit[14]) begin
                in_pkt[ej_vc] <= 1'b1;
            end
        end
    end
`else
    logic unused_ej;
    assign unused_ej = ^{ej_flit[20:16], ej_flit[13:0], LOCAL_ID};
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ni_injector.sv
// Self-checking bench for ni_injector: scoreboard of expected injected flits plus ejection counter model.
module tb_ni_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [13:0] pkt_dst;
    logic [3:0]  pkt_vc;
    logic [3:0]  pkt_len;
    logic [15:0] can_inject;
    logic        inj_take;
    logic [21:0] inj_flit;
    logic [21:0] ej_flit;
    logic        ej_strobe;
    logic [15:0] rx_flits;
    logic [15:0] rx_pkts;
    logic        err;
    logic        done;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [21:0] exp_q[$];
    logic [15:0] exp_flits = '0;
    logic [15:0] exp_pkts  = '0;

    ni_injector #(.FIFO_DEPTH(4), .LOCAL_ID(14'd0)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_dst(pkt_dst), .pkt_vc(pkt_vc), .pkt_len(pkt_len),
        .can_inject(can_inject), .inj_take(inj_take), .inj_flit(inj_flit),
        .ej_flit(ej_flit), .ej_strobe(ej_strobe),
        .rx_flits(rx_flits), .rx_pkts(rx_pkts), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic [13:0] dst, input logic [3:0] vc, input logic [3:0] len);
        int unsigned n;
        int unsigned waited;
        n = (len == 4'd0) ? 1 : int'(len);
        waited = 0;
        while (!pkt_ready && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready_timeout: pkt_ready=%b required 1", pkt_ready);
        end
        pkt_valid = 1'b1;
        pkt_dst = dst;
        pkt_vc = vc;
        pkt_len = len;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, vc, 1'b0, (i == n - 1), (i == 0), dst});
        end
        step();
        pkt_valid = 1'b0;
    endtask

    task automatic take_flit(input string name);
        logic [21:0] exp;
        int unsigned waited;
        waited = 0;
        while (!inj_flit[21] && waited < 50) begin
            step();
            waited++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
        checks++;
        if (inj_flit !== exp) begin
            errors++;
            $display("FAIL %s_flit: inj_flit=%h required %h", name, inj_flit, exp);
        end
        inj_take = 1'b1;
        step();
        inj_take = 1'b0;
        checks++;
        if (inj_flit !== 22'h0) begin
            errors++;
            $display("FAIL %s_cleared: inj_flit=%h required 000000", name, inj_flit);
        end
    endtask

    task automatic strobe(input logic [21:0] f);
        ej_flit = f;
        ej_strobe = 1'b1;
        if (f[21]) begin
            exp_flits = exp_flits + 16'd1;
            if (f[15]) exp_pkts = exp_pkts + 16'd1;
        end
        step();
        ej_strobe = 1'b0;
        ej_flit = '0;
    endtask

    task automatic check_idle_state(input string name);
        checks++;
        if (inj_flit !== 22'h0 || pkt_ready !== 1'b1 || done !== 1'b1 ||
            rx_flits !== 16'd0 || rx_pkts !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: flit=%h ready=%b done=%b rx_flits=%0d rx_pkts=%0d err=%b required 000000 1 1 0 0 0",
                     name, inj_flit, pkt_ready, done, rx_flits, rx_pkts, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_flits = '0;
        exp_pkts = '0;
        check_idle_state("reset");
    endtask

    task automatic test_single();
        push_desc(14'd12, 4'd1, 4'd1);
        checks++;
        if (inj_flit !== 22'h0) begin
            errors++;
            $display("FAIL single_lat_n: inj_flit=%h required 000000", inj_flit);
        end
        step();
        checks++;
        if (inj_flit !== 22'h0) begin
            errors++;
            $display("FAIL single_lat_n1: inj_flit=%h required 000000", inj_flit);
        end
        step();
        checks++;
        if (inj_flit !== {1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 14'd12}) begin
            errors++;
            $display("FAIL single_lat_n2: inj_flit=%h required %h", inj_flit,
                     {1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 14'd12});
        end
        take_flit("single");
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL single_done: done=%b required 1", done);
        end
    endtask

    task automatic test_multi();
        push_desc(14'd5, 4'd2, 4'd3);
        take_flit("multi0");
        take_flit("multi1");
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL multi_not_popped: done=%b required 0", done);
        end
        take_flit("multi2");
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL multi_done: done=%b required 1", done);
        end
    endtask

    task automatic test_blocked();
        logic seen;
        can_inject = 16'hFFF7;
        push_desc(14'd33, 4'd3, 4'd1);
        seen = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            step();
            if (inj_flit !== 22'h0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL blocked_quiet: flit seen=%b required 0", seen);
        end
        can_inject = 16'hFFFF;
        step();
        checks++;
        if (inj_flit[21] !== 1'b1) begin
            errors++;
            $display("FAIL blocked_release: full=%b required 1", inj_flit[21]);
        end
        take_flit("blocked");
    endtask

    task automatic test_full();
        logic ready_seen;
        for (int unsigned i = 0; i < 4; i++) begin
            push_desc(14'(20 + i), 4'd0, 4'd0);
        end
        checks++;
        if (pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: pkt_ready=%b required 0", pkt_ready);
        end
        pkt_valid = 1'b1;
        pkt_dst = 14'd99;
        pkt_vc = 4'd0;
        pkt_len = 4'd1;
        ready_seen = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            if (pkt_ready !== 1'b0) ready_seen = 1'b1;
        end
        pkt_valid = 1'b0;
        checks++;
        if (ready_seen !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: ready seen=%b required 0", ready_seen);
        end
        take_flit("full0");
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_restore: pkt_ready=%b required 1", pkt_ready);
        end
        take_flit("full1");
        take_flit("full2");
        take_flit("full3");
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL full_no_fifth: done=%b required 1", done);
        end
    endtask

    task automatic test_eject();
        logic exp_err;
        strobe({1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 14'd0});
        strobe({1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 14'd0});
        strobe({1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 14'd0});
        strobe({1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 14'd0});
        checks++;
        if (rx_flits !== exp_flits || rx_pkts !== exp_pkts || err !== 1'b0) begin
            errors++;
            $display("FAIL eject_counts: flits=%0d pkts=%0d err=%b required %0d %0d 0",
                     rx_flits, rx_pkts, err, exp_flits, exp_pkts);
        end
`ifdef NI_EJECT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        strobe({1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 14'd0});
        checks++;
        if (err !== exp_err || rx_flits !== exp_flits) begin
            errors++;
            $display("FAIL eject_err: err=%b flits=%0d required %b %0d", err, rx_flits, exp_err, exp_flits);
        end
        strobe({1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 14'd0});
        step();
        checks++;
        if (err !== exp_err || rx_pkts !== exp_pkts) begin
            errors++;
            $display("FAIL eject_sticky: err=%b pkts=%0d required %b %0d", err, rx_pkts, exp_err, exp_pkts);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned waited;
        push_desc(14'd7, 4'd1, 4'd3);
        push_desc(14'd8, 4'd1, 4'd2);
        take_flit("mid0");
        waited = 0;
        while (!inj_flit[21] && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (inj_flit[21] !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold: full=%b required 1", inj_flit[21]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_flits = '0;
        exp_pkts = '0;
        check_idle_state("mid_reset");
        push_desc(14'd9, 4'd2, 4'd1);
        take_flit("post_reset");
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done: done=%b required 1", done);
        end
    endtask

    initial begin
        rst = 1'b1;
        pkt_valid = 1'b0;
        pkt_dst = '0;
        pkt_vc = '0;
        pkt_len = '0;
        can_inject = 16'hFFFF;
        inj_take = 1'b0;
        ej_flit = '0;
        ej_strobe = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_blocked();
        test_full();
        test_eject();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
